// File: rtl/insn_buffer_pkg.sv
// RafiTypes: shared types for the instruction buffer slice.
// Holds the halfword entry record, the virtual address type and the
// occupancy counter type used by insn_buffer and insn_buffer_storage.
package RafiTypes;

  // Halfword capacity of the instruction buffer ring.
  localparam int INSN_BUFFER_ENTRY_COUNT = 4;

  typedef logic [31:0] vaddr_t;

  // Occupancy counter, wide enough for 0..INSN_BUFFER_ENTRY_COUNT.
  typedef logic [2:0] insn_buffer_entry_count_t;

  // One fetched halfword together with its fetch-side attributes.
  typedef struct packed {
    vaddr_t      pc;
    logic [15:0] insn;
    logic        fault;
    logic        interruptValid;
    logic [3:0]  interruptCode;
  } InsnBufferEntry;

endpackage

// File: rtl/insn_buffer_storage.sv
// insn_buffer_storage: four-entry halfword ring with read/write pointers
// and an occupancy count. The two head halfwords are presented
// combinationally; the caller decides how many of them are consumed.
module insn_buffer_storage
  import RafiTypes::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic                     wr_two,
  input  InsnBufferEntry           wr_entry0,
  input  InsnBufferEntry           wr_entry1,
  input  logic                     rd_en,
  input  logic                     rd_two,
  output InsnBufferEntry           hw0,
  output InsnBufferEntry           hw1,
  output insn_buffer_entry_count_t count
);

  InsnBufferEntry mem_q [INSN_BUFFER_ENTRY_COUNT];

  logic [1:0]               rp_q, rp_d;
  logic [1:0]               wp_q, wp_d;
  insn_buffer_entry_count_t count_q, count_d;
  insn_buffer_entry_count_t enq_amt, deq_amt;
  logic [1:0]               rp_plus1, wp_plus1;

  assign rp_plus1 = rp_q + 2'd1;
  assign wp_plus1 = wp_q + 2'd1;

  // Pointer and occupancy update; flush empties the ring outright.
  always_comb begin
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    enq_amt = '0;
    deq_amt = '0;
    if (wr_en) enq_amt = wr_two ? 3'd2 : 3'd1;
    if (rd_en) deq_amt = rd_two ? 3'd2 : 3'd1;
    if (flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      rp_d    = rp_q + deq_amt[1:0];
      wp_d    = wp_q + enq_amt[1:0];
      count_d = count_q + enq_amt - deq_amt;
    end
  end

  // Pointer and count registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Entry storage is data only and deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en && !flush && !rst) begin
      mem_q[wp_q] <= wr_entry0;
      if (wr_two) mem_q[wp_plus1] <= wr_entry1;
    end
  end

  assign hw0   = mem_q[rp_q];
  assign hw1   = mem_q[rp_plus1];
  assign count = count_q;

endmodule

// File: rtl/insn_buffer.sv
// insn_buffer: halfword instruction buffer between fetch and decode.
// Classifies the head as trap / compressed / 32-bit and assembles the
// instruction handed to decode. Compressed (RVC) support is compiled in
// when RAFI_INSN_BUFFER_RVC_EN is defined; otherwise every non-trap head
// is treated as a 32-bit instruction.
module insn_buffer
  import RafiTypes::InsnBufferEntry;
  import RafiTypes::vaddr_t;
  import RafiTypes::insn_buffer_entry_count_t;
#(
  parameter int INSN_BUFFER_ENTRY_COUNT = RafiTypes::INSN_BUFFER_ENTRY_COUNT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [1:0]     enqValid,
  input  InsnBufferEntry enqEntry0,
  input  InsnBufferEntry enqEntry1,
  output logic           enqReady,
  output logic           deqValid,
  input  logic           deqReady,
  output logic [31:0]    deqInsn,
  output vaddr_t         deqPc,
  output logic           deqCompressed,
  output logic           deqFault,
  output logic           deqInterruptValid,
  output logic [3:0]     deqInterruptCode
);

  localparam insn_buffer_entry_count_t READY_LIMIT =
    insn_buffer_entry_count_t'(INSN_BUFFER_ENTRY_COUNT - 2);

  InsnBufferEntry           hw0, hw1;
  insn_buffer_entry_count_t count;
  logic                     is_trap, is_compressed, is_single;
  logic                     wr_en, rd_en;

  // hw1 only contributes its instruction bits and fault flag.
  logic unused_hw1;
  assign unused_hw1 = &{1'b0, hw1.pc, hw1.interruptValid, hw1.interruptCode};

  assign enqReady = (count <= READY_LIMIT);
  assign wr_en    = enqValid[0] && enqReady;
  assign rd_en    = deqValid && deqReady;

  insn_buffer_storage u_storage (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_two    (enqValid[1]),
    .wr_entry0 (enqEntry0),
    .wr_entry1 (enqEntry1),
    .rd_en     (rd_en),
    .rd_two    (!is_single),
    .hw0       (hw0),
    .hw1       (hw1),
    .count     (count)
  );

  // Head classification and instruction assembly.
  always_comb begin
    is_trap       = hw0.fault || hw0.interruptValid;
`ifdef RAFI_INSN_BUFFER_RVC_EN
    is_compressed = !is_trap && (hw0.insn[1:0] != 2'b11);
`else
    is_compressed = 1'b0;
`endif
    is_single     = is_trap || is_compressed;

    deqValid          = (count != '0) && (is_single || (count >= 3'd2));
    deqPc             = hw0.pc;
    deqCompressed     = is_compressed;
    deqInterruptValid = hw0.interruptValid;
    deqInterruptCode  = hw0.interruptCode;
    deqInsn           = {16'h0, hw0.insn};
    deqFault          = hw0.fault;
    if (!is_single) begin
      deqInsn  = {hw1.insn, hw0.insn};
      deqFault = hw0.fault || hw1.fault;
    end
  end

endmodule

// File: tb/tb_insn_buffer.sv
// tb_insn_buffer: directed and randomized checks of insn_buffer against a
// queue-based model of the halfword buffer. Honours RAFI_INSN_BUFFER_RVC_EN
// in the same way as the design.
module tb_insn_buffer;
  import RafiTypes::*;

  logic           clk = 1'b0;
  logic           rst, flush, deq_ready;
  logic [1:0]     enq_valid;
  InsnBufferEntry enq_e0, enq_e1;
  logic           enq_ready, deq_valid, deq_comp, deq_fault, deq_iv;
  logic [31:0]    deq_insn;
  vaddr_t         deq_pc;
  logic [3:0]     deq_code;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_known = 0;
  InsnBufferEntry mq[$];
  vaddr_t pc_ctr = 32'h8000_0000;

`ifdef RAFI_INSN_BUFFER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  always #5 clk = ~clk;

  insn_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .enqValid          (enq_valid),
    .enqEntry0         (enq_e0),
    .enqEntry1         (enq_e1),
    .enqReady          (enq_ready),
    .deqValid          (deq_valid),
    .deqReady          (deq_ready),
    .deqInsn           (deq_insn),
    .deqPc             (deq_pc),
    .deqCompressed     (deq_comp),
    .deqFault          (deq_fault),
    .deqInterruptValid (deq_iv),
    .deqInterruptCode  (deq_code)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic InsnBufferEntry mk(input vaddr_t pc, input logic [15:0] insn,
                                        input logic f, input logic iv, input logic [3:0] code);
    InsnBufferEntry e;
    e.pc = pc; e.insn = insn; e.fault = f; e.interruptValid = iv; e.interruptCode = code;
    return e;
  endfunction

  task automatic idle();
    rst = 0; flush = 0; deq_ready = 0; enq_valid = 2'b00;
  endtask

  task automatic enq(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1);
    enq_valid = v;
    enq_e0 = mk(pc_ctr, i0, 1'b0, 1'b0, 4'h0);
    enq_e1 = mk(pc_ctr + 32'd2, i1, 1'b0, 1'b0, 4'h0);
    pc_ctr += (v[1] ? 32'd4 : 32'd2);
  endtask

  // One clock: compare the DUT against the model mid-cycle, then advance the model.
  task automatic cycle();
    bit          e_ready, e_valid, e_trap, e_comp, e_single, e_fault;
    logic [31:0] e_insn;
    int          n;
    @(negedge clk);
    if (enq_valid == 2'b10) begin
      n_fail++;
      $display("FAIL illegal_enq_valid: got 10 required 00/01/11");
    end
    e_ready = (mq.size() <= INSN_BUFFER_ENTRY_COUNT - 2);
    e_valid = 0; e_comp = 0; e_single = 1; e_fault = 0; e_insn = '0;
    if (mq.size() > 0) begin
      e_trap   = mq[0].fault || mq[0].interruptValid;
      e_comp   = RVC && !e_trap && (mq[0].insn[1:0] != 2'b11);
      e_single = e_trap || e_comp;
      e_valid  = e_single || (mq.size() >= 2);
      if (e_single) begin
        e_insn  = {16'h0, mq[0].insn};
        e_fault = mq[0].fault;
      end else if (e_valid) begin
        e_insn  = {mq[1].insn, mq[0].insn};
        e_fault = mq[0].fault || mq[1].fault;
      end
    end
    if (model_known) begin
      chk("enqReady", enq_ready, e_ready);
      chk("deqValid", deq_valid, e_valid);
      if (e_valid) begin
        chk("deqInsn", deq_insn, e_insn);
        chk("deqPc", deq_pc, mq[0].pc);
        chk("deqCompressed", deq_comp, e_comp);
        chk("deqFault", deq_fault, e_fault);
        chk("deqInterruptValid", deq_iv, mq[0].interruptValid);
        chk("deqInterruptCode", deq_code, mq[0].interruptCode);
      end
    end
    if (rst) begin
      mq.delete();
      model_known = 1;
    end else if (flush) begin
      mq.delete();
    end else if (model_known) begin
      if (e_valid && deq_ready) begin
        $display("deq pc=%h insn=%h comp=%0d fault=%0d irq=%0d", mq[0].pc, e_insn,
                 e_comp, e_fault, mq[0].interruptValid);
        n = e_single ? 1 : 2;
        for (int k = 0; k < n; k++) void'(mq.pop_front());
      end
      if (enq_valid[0] && e_ready) begin
        mq.push_back(enq_e0);
        if (enq_valid[1]) mq.push_back(enq_e1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    enq_e0 = '0; enq_e1 = '0;
    rst = 1;
    cycle();
    idle();
    chk("reset_enqReady", enq_ready, 1);
    chk("reset_deqValid", deq_valid, 0);

    // 32-bit pair in one enqueue
    pc_ctr = 32'h8000_0000;
    enq(2'b11, 16'h0093, 16'h0010); cycle(); idle();
    chk("pair_valid", deq_valid, 1);
    chk("pair_insn", deq_insn, 32'h0010_0093);
    chk("pair_comp", deq_comp, 0);
    chk("pair_pc", deq_pc, 32'h8000_0000);
    deq_ready = 1; cycle(); idle();
    chk("pair_drained", deq_valid, 0);

    // two compressed halfwords (or one 32-bit without RVC)
    pc_ctr = 32'h8000_0000;
    enq(2'b11, 16'h4505, 16'h0001); cycle(); idle();
    if (RVC) begin
      chk("rvc0_insn", deq_insn, 32'h0000_4505);
      chk("rvc0_pc", deq_pc, 32'h8000_0000);
      chk("rvc0_comp", deq_comp, 1);
      deq_ready = 1; cycle();
      chk("rvc1_insn", deq_insn, 32'h0000_0001);
      chk("rvc1_pc", deq_pc, 32'h8000_0002);
      cycle(); idle();
    end else begin
      chk("norvc_insn", deq_insn, 32'h0001_4505);
      chk("norvc_comp", deq_comp, 0);
      deq_ready = 1; cycle(); idle();
    end
    chk("rvc_drained", deq_valid, 0);

    // split 32-bit instruction across two single enqueues
    enq(2'b01, 16'h0093, 16'h0000); cycle(); idle();
    chk("split_half_valid", deq_valid, 0);
    enq(2'b01, 16'h0010, 16'h0000); cycle(); idle();
    chk("split_valid", deq_valid, 1);
    chk("split_insn", deq_insn, 32'h0010_0093);
    deq_ready = 1; cycle(); idle();

    // fill, ignored writes, wrap-around with simultaneous enq/deq
    enq(2'b11, 16'h1117, 16'h2222); cycle();
    enq(2'b11, 16'h3337, 16'h4444); cycle(); idle();
    chk("full_enqReady", enq_ready, 0);
    chk("full_head", deq_insn, 32'h2222_1117);
    enq(2'b11, 16'h5557, 16'h6666); cycle(); idle();
    chk("full_ignored_head", deq_insn, 32'h2222_1117);
    deq_ready = 1; enq(2'b11, 16'h5557, 16'h6666); cycle(); idle();
    chk("after_deq_head", deq_insn, 32'h4444_3337);
    chk("after_deq_enqReady", enq_ready, 1);
    deq_ready = 1; enq(2'b11, 16'h7777, 16'h8888); cycle(); idle();
    chk("simul_head", deq_insn, 32'h8888_7777);
    enq(2'b11, 16'h9993, 16'haaaa); cycle(); idle();
    chk("wrapped_full_enqReady", enq_ready, 0);
    chk("wrapped_full_head", deq_insn, 32'h8888_7777);
    deq_ready = 1; cycle(); cycle(); idle();
    chk("wrap_drained", deq_valid, 0);

    // faults and interrupts
    enq_valid = 2'b01; enq_e0 = mk(32'h100, 16'h0013, 1'b1, 1'b0, 4'h0); cycle(); idle();
    chk("fault_valid", deq_valid, 1);
    chk("fault_flag", deq_fault, 1);
    chk("fault_insn", deq_insn, 32'h0000_0013);
    deq_ready = 1; cycle(); idle();
    chk("fault_single_consumed", deq_valid, 0);
    enq_valid = 2'b11;
    enq_e0 = mk(32'h200, 16'h0093, 1'b0, 1'b0, 4'h0);
    enq_e1 = mk(32'h202, 16'h0010, 1'b1, 1'b0, 4'h0);
    cycle(); idle();
    chk("hi_fault_flag", deq_fault, 1);
    chk("hi_fault_insn", deq_insn, 32'h0010_0093);
    deq_ready = 1; cycle(); idle();
    chk("hi_fault_two_consumed", deq_valid, 0);
    enq_valid = 2'b01; enq_e0 = mk(32'h300, 16'h0093, 1'b0, 1'b1, 4'h5); cycle(); idle();
    chk("irq_valid", deq_iv, 1);
    chk("irq_code", deq_code, 4'h5);
    chk("irq_insn", deq_insn, 32'h0000_0093);
    deq_ready = 1; cycle(); idle();

    // flush and reset at count=3 with concurrent enqueue
    enq(2'b11, 16'h0093, 16'h0010); cycle();
    enq(2'b01, 16'h0113, 16'h0000); cycle(); idle();
    chk("cnt3_enqReady", enq_ready, 0);
    flush = 1; deq_ready = 1; enq(2'b11, 16'h0193, 16'h0020); cycle(); idle();
    chk("flush_deqValid", deq_valid, 0);
    chk("flush_enqReady", enq_ready, 1);
    enq(2'b11, 16'h0093, 16'h0010); cycle();
    enq(2'b01, 16'h0113, 16'h0000); cycle(); idle();
    rst = 1; flush = 1; deq_ready = 1; enq(2'b11, 16'h0193, 16'h0020); cycle(); idle();
    chk("rst_deqValid", deq_valid, 0);
    chk("rst_enqReady", enq_ready, 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int sel;
      sel = $urandom_range(2);
      enq_valid = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      enq_e0 = mk(pc_ctr, 16'($urandom), $urandom_range(15) == 0,
                  $urandom_range(15) == 0, 4'($urandom));
      enq_e1 = mk(pc_ctr + 32'd2, 16'($urandom), $urandom_range(15) == 0,
                  $urandom_range(15) == 0, 4'($urandom));
      pc_ctr += 32'd4;
      deq_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(49) == 0);
      rst = ($urandom_range(199) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
